// File: rtl/fifo_umbral.sv
// Synchronous FIFO with registered status flags and programmable almost-full /
// almost-empty thresholds. Define FIFO_ERROR_STICKY_EN to make `error` sticky until reset.
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3,
    parameter int U_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic [U_WIDTH-1:0]    umbral_alto,
    input  logic [U_WIDTH-1:0]    umbral_bajo,
    output logic [U_WIDTH-1:0]    fifo_count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int                 DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [U_WIDTH-1:0] DEPTH_U = U_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [U_WIDTH-1:0]    count_r;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  valid_out_r;
    logic                  empty_r;
    logic                  full_r;
    logic                  almost_full_r;
    logic                  almost_empty_r;
    logic                  error_r;

    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  overflow_s;
    logic                  underflow_s;
    logic [U_WIDTH-1:0]    count_next_s;

    // Access acceptance, fault detection and next occupancy.
    always_comb begin
        wr_acc_s     = wr_enable && (!full_r || rd_enable);
        rd_acc_s     = rd_enable && !empty_r;
        overflow_s   = wr_enable && full_r && !rd_enable;
        underflow_s  = rd_enable && empty_r;
        count_next_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + U_WIDTH'(1);
            2'b01:   count_next_s = count_r - U_WIDTH'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy and read data path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            data_out_r  <= '0;
            valid_out_r <= 1'b0;
        end else begin
            count_r     <= count_next_s;
            valid_out_r <= rd_acc_s;
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
            end
            if (rd_acc_s) begin
                data_out_r <= mem_r[rd_ptr_r];
                rd_ptr_r   <= rd_ptr_r + ADDR_WIDTH'(1);
            end
        end
    end

    // Status flags evaluated on next occupancy against the thresholds at this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            empty_r        <= 1'b1;
            full_r         <= 1'b0;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            empty_r        <= (count_next_s == U_WIDTH'(0));
            full_r         <= (count_next_s == DEPTH_U);
            almost_full_r  <= (count_next_s >= umbral_alto);
            almost_empty_r <= (count_next_s <= umbral_bajo);
        end
    end

    // Error flag: sticky until reset, or a one-cycle pulse per offending access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_r <= 1'b0;
        end else begin
`ifdef FIFO_ERROR_STICKY_EN
            error_r <= error_r || overflow_s || underflow_s;
`else
            error_r <= overflow_s || underflow_s;
`endif
        end
    end

    assign data_out     = data_out_r;
    assign valid_out    = valid_out_r;
    assign fifo_count   = count_r;
    assign empty        = empty_r;
    assign full         = full_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;
    assign error        = error_r;

endmodule

// File: doc/fifo_umbral.md
# fifo_umbral

Synchronous FIFO with programmable almost-full/almost-empty thresholds ("umbrales"). It is the buffer instantiated for the main, VC0, VC1, D0 and D1 FIFOs of the transmit-layer datapath. It consumes the threshold values the layer state machine latches during INIT, and it returns the `empty` and `error` status the state machine uses for its IDLE/ACTIVE/ERROR decisions.

## Interface
Parameters:
- `DATA_WIDTH`, 6: width of one FIFO word.
- `ADDR_WIDTH`, 3: log2 of the depth; depth is `2**ADDR_WIDTH`, 8 by default.
- `U_WIDTH`, 4: width of the threshold and count values. Must be `ADDR_WIDTH+1`.

Ports:
- `clk`  in  1  single clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_enable`  in  1  write request.
- `data_in`  in  DATA_WIDTH  write data.
- `rd_enable`  in  1  read request.
- `data_out`  out  DATA_WIDTH  registered read data.
- `valid_out`  out  1  `data_out` holds a word popped on the previous edge.
- `umbral_alto`  in  U_WIDTH  almost-full threshold, from the state machine's `umbral_*_out`.
- `umbral_bajo`  in  U_WIDTH  almost-empty threshold.
- `fifo_count`  out  U_WIDTH  number of stored words, 0..depth.
- `empty`  out  1  `fifo_count == 0`.
- `full`  out  1  `fifo_count == depth`.
- `almost_full`  out  1  `fifo_count >= umbral_alto`.
- `almost_empty`  out  1  `fifo_count <= umbral_bajo`.
- `error`  out  1  overflow or underflow detected.

## Operation
- Storage is a `2**ADDR_WIDTH` × `DATA_WIDTH` register array.
- Pointers:
  - `wr_ptr` and `rd_ptr` are ADDR_WIDTH wide and wrap modulo depth (7→0).
  - `fifo_count` tracks occupancy independently of the pointers.
- Write accepted when `wr_enable && (!full || rd_enable)`: stores `data_in` at `wr_ptr`, then increments `wr_ptr`.
- Read accepted when `rd_enable && !empty`: `data_out <= mem[rd_ptr]`, `rd_ptr` increments, and `valid_out` is 1 on the next cycle.
  - Otherwise `valid_out` is 0 and `data_out` holds its last value.
- Count update per edge: +1 on accepted write only, −1 on accepted read only, unchanged for both or neither.
- Simultaneous read and write:
  - When empty: the write is accepted. The read is rejected and flags underflow; the data is not bypassed.
  - When full: both are accepted, count stays at depth, and no overflow is flagged.
- Overflow is `wr_enable && full && !rd_enable`; the data is dropped. Underflow is `rd_enable && empty`.
  - On either event, `error` is set on the next edge (see Configuration).
  - Pointers and count are never corrupted by a rejected access.
- Flag registers:
  - `empty`, `full`, `almost_full` and `almost_empty` are registered, computed from next-count against the thresholds present at that edge.
  - A threshold change is therefore visible one cycle later.
  - `umbral_alto = 0` makes `almost_full` constantly 1 after the first edge. `umbral_bajo >= depth` makes `almost_empty` constantly 1.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers and count go to 0 and memory contents become don't-care.
  - `data_out = 0`, `valid_out = 0`, `empty = 1`, `full = 0`, `almost_full = 0`, `almost_empty = 1`, `error = 0`, `fifo_count = 0`.

## Timing
- Write-to-visible: a word written at edge N raises `fifo_count` and clears `empty` at edge N; it can be popped at edge N+1.
- Read latency is one cycle: a read accepted at edge N presents `data_out` and `valid_out` after edge N.
- Back-to-back reads and writes are sustained at one word per cycle with no bubbles.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `FIFO_ERROR_STICKY_EN`:
  - Defined: `error` is sticky; once set it stays 1 until `reset` is asserted. This matches the state machine's ERROR state, which exits only through reset.
  - Undefined: `error` is a one-cycle pulse per offending access, high for the cycle after each overflow or underflow edge.

## Test plan
- Reset/idle: assert `reset=0` mid-burst after 3 writes → all outputs take their reset values immediately. After release, `empty=1`, `almost_empty=1`, `fifo_count=0`.
- Fill/drain with wrap: thresholds `umbral_alto=6`, `umbral_bajo=1`; write 0x01..0x08, then read 8, then write and read 4 more.
  - `almost_full` rises after the 6th write and `full` after the 8th.
  - Reads return 0x01..0x08 in order with `valid_out` one cycle after each `rd_enable`.
  - `almost_empty` is 1 at count ≤1.
  - Pointers wrap correctly.
- Overflow: full FIFO, `wr_enable=1`, `data_in=0x3F`, `rd_enable=0`.
  - `error=1` next cycle and count stays 8.
  - 0x3F never appears on `data_out`.
  - Sticky build: `error` stays 1 until reset. Non-sticky build: a 1-cycle pulse.
- Underflow with simultaneous write: empty FIFO, `rd_enable=1` and `wr_enable=1` with 0x15.
  - `error` is set, `valid_out=0`, count becomes 1.
  - The next read returns 0x15.
- Full simultaneous read/write: FIFO full, `rd_enable=wr_enable=1` for 4 cycles → count stays 8, `error` stays 0, data order is preserved.
- Threshold change: count=3, change `umbral_bajo` from 2 to 3 → `almost_empty` rises exactly one cycle later.
